// File: rtl/gate_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_pkg
// Description : Shared definitions for the gate sweep controller.
//               - Sweep FSM state encoding.
//               - Reference truth tables for common 2-input gates. Each table
//                 is indexed by {A,B}, so bit 3 is the A=1,B=1 result.
//               - Width of the settle counter.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_sweep_pkg;

  // Width of the settle counter. SETTLE values of 1..15 fit in it.
  localparam int SETTLE_W = 4;

  // Sweep FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Reference truth tables, indexed by {A,B}
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage
`default_nettype wire

// File: rtl/gate_sweep_timer.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_timer
// Description : Settle-window counter for the gate sweep controller.
//               i_load clears the count. i_count increments it.
//               o_expire flags the last settle cycle (count == LIMIT-1).
// Ports       : clk      - rising-edge clock
//               rst      - synchronous active-high reset
//               i_load   - clear count (has priority over i_count)
//               i_count  - increment count
//               o_expire - count has reached LIMIT-1
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_timer
  import gate_sweep_pkg::*;
#(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);

  localparam logic [SETTLE_W-1:0] c_LAST = SETTLE_W'(LIMIT - 1);

  logic [SETTLE_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + SETTLE_W'(1);
    end
  end

  assign o_expire = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_ctrl
// Description : Drives all four {A,B} input combinations into a 2-input gate
//               under test. After each drive it waits SETTLE cycles, samples
//               the gate output and compares it against the EXPECT truth
//               table. Per-vector mismatches are accumulated in fail_vec, and
//               pass is reported with a one-cycle done pulse.
// Options     : GATE_SWEEP_CAPTURE_EN - adds the z_table output, which holds
//               the raw sampled gate outputs.
// Ports       : clk      - rising-edge clock
//               rst      - synchronous active-high reset
//               start    - sweep request (only accepted in IDLE)
//               abort    - cancel an active sweep
//               z_in     - output of the gate under test
//               a_out    - gate input A
//               b_out    - gate input B
//               busy     - sweep in progress
//               done     - one-cycle completion pulse
//               pass     - result of the last completed sweep
//               z_table  - captured z_in per vector (option only)
//               fail_vec - per-vector mismatch flags, indexed by {A,B}
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter logic [3:0] EXPECT = TT_AND,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       z_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
`ifdef GATE_SWEEP_CAPTURE_EN
  output logic [3:0] z_table,
`endif
  output logic [3:0] fail_vec
);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [1:0] r_idx;
  logic [1:0] w_idx_nxt;
  logic       r_a, r_b, r_busy, r_done, r_pass;
  logic       w_a_nxt, w_b_nxt, w_busy_nxt, w_done_nxt, w_pass_nxt;
  logic [3:0] r_fail;
  logic [3:0] w_fail_nxt;
  logic       w_expire;
  logic       w_tmr_load;
  logic       w_tmr_count;
`ifdef GATE_SWEEP_CAPTURE_EN
  logic [3:0] r_ztab;
  logic [3:0] w_ztab_nxt;
`endif

  // The counter is held at zero outside SETTLE. This means every SETTLE
  // window starts from zero without an explicit load on entry. Abort also
  // clears it.
  assign w_tmr_load  = (r_state != ST_SETTLE) || abort;
  assign w_tmr_count = (r_state == ST_SETTLE);

  gate_sweep_timer #(
    .LIMIT(SETTLE)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_tmr_load),
    .i_count (w_tmr_count),
    .o_expire(w_expire)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 4'd0;
`ifdef GATE_SWEEP_CAPTURE_EN
      r_ztab  <= 4'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_fail  <= w_fail_nxt;
`ifdef GATE_SWEEP_CAPTURE_EN
      r_ztab  <= w_ztab_nxt;
`endif
    end
  end

  // Next-state logic. Abort overrides the SETTLE/SAMPLE transitions.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort)         w_state_nxt = ST_IDLE;
        else if (w_expire) w_state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)              w_state_nxt = ST_IDLE;
        else if (r_idx == 2'd3) w_state_nxt = ST_DONE;
        else                    w_state_nxt = ST_SETTLE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs. Each value is computed so that it
  // lines up with the state it is registered alongside.
  always_comb begin
    w_idx_nxt  = r_idx;
    w_a_nxt    = r_a;
    w_b_nxt    = r_b;
    w_pass_nxt = r_pass;
    w_fail_nxt = r_fail;
`ifdef GATE_SWEEP_CAPTURE_EN
    w_ztab_nxt = r_ztab;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_idx_nxt  = 2'd0;
          w_a_nxt    = 1'b0;
          w_b_nxt    = 1'b0;
          w_pass_nxt = 1'b0;
          w_fail_nxt = 4'd0;
`ifdef GATE_SWEEP_CAPTURE_EN
          w_ztab_nxt = 4'd0;
`endif
        end
      end
      ST_SETTLE, ST_SAMPLE: begin
        if (abort) begin
          // The partial fail_vec is kept for inspection.
          w_idx_nxt  = 2'd0;
          w_a_nxt    = 1'b0;
          w_b_nxt    = 1'b0;
          w_pass_nxt = 1'b0;
        end else if (r_state == ST_SAMPLE) begin
          w_fail_nxt[r_idx] = z_in ^ EXPECT[r_idx];
`ifdef GATE_SWEEP_CAPTURE_EN
          w_ztab_nxt[r_idx] = z_in;
`endif
          if (r_idx == 2'd3) begin
            // pass must include the mismatch flag sampled this cycle.
            w_pass_nxt = (w_fail_nxt == 4'd0);
          end else begin
            w_idx_nxt          = r_idx + 2'd1;
            {w_a_nxt, w_b_nxt} = r_idx + 2'd1;
          end
        end
      end
      ST_DONE: begin
        // Park the gate inputs at 00 while idle.
        w_idx_nxt = 2'd0;
        w_a_nxt   = 1'b0;
        w_b_nxt   = 1'b0;
      end
      default: begin
        w_idx_nxt = 2'd0;
      end
    endcase
    w_busy_nxt = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  assign a_out    = r_a;
  assign b_out    = r_b;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign fail_vec = r_fail;
`ifdef GATE_SWEEP_CAPTURE_EN
  assign z_table  = r_ztab;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_sweep_ctrl
// Description : Testbench for gate_sweep_ctrl. Three controllers share
//               start/abort/rst:
//                 dut0 - EXPECT=AND,  SETTLE=2
//                 dut1 - EXPECT=NAND, SETTLE=2
//                 dut2 - EXPECT=OR,   SETTLE=1
//               Each controller drives its own gate under test. The gate is
//               either an AND built from two NANDs, or a constant 0.
//               A timing model predicts every output on every cycle.
//               Directed scenarios add literal expectations on top.
//               Honours GATE_SWEEP_CAPTURE_EN (z_table).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_ctrl;
  import gate_sweep_pkg::*;

  localparam int c_N = 3;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  bit   gmode;  // 0: AND made of two NANDs, 1: gate output stuck at 0

  wire [c_N-1:0] a_o, b_o, busy_o, done_o, pass_o, z_in, w_nand;
  wire [3:0]     fail_o [c_N];
`ifdef GATE_SWEEP_CAPTURE_EN
  wire [3:0]     zt_o [c_N];
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < c_N; g++) begin : g_dut
    assign w_nand[g] = ~(a_o[g] & b_o[g]);
    assign z_in[g]   = gmode ? 1'b0 : ~(w_nand[g] & w_nand[g]);
    gate_sweep_ctrl #(
      .EXPECT((g == 0) ? TT_AND : (g == 1) ? TT_NAND : TT_OR),
      .SETTLE((g == 2) ? 1 : 2)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .abort   (abort),
      .z_in    (z_in[g]),
      .a_out   (a_o[g]),
      .b_out   (b_o[g]),
      .busy    (busy_o[g]),
      .done    (done_o[g]),
      .pass    (pass_o[g]),
`ifdef GATE_SWEEP_CAPTURE_EN
      .z_table (zt_o[g]),
`endif
      .fail_vec(fail_o[g])
    );
  end

  function automatic logic [3:0] exp_of(int d);
    return (d == 0) ? TT_AND : (d == 1) ? TT_NAND : TT_OR;
  endfunction

  function automatic int settle_of(int d);
    return (d == 2) ? 1 : 2;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A sweep is modelled as elapsed time since acceptance. Vector v occupies
  // cycles v*(S+1) .. v*(S+1)+S, and its last cycle is the sample.
  bit           m_valid = 1'b0;
  bit           m_run [c_N];
  bit           m_dc  [c_N];
  int           m_t   [c_N];
  logic [c_N-1:0] e_a, e_b, e_busy, e_done, e_pass;
  logic [3:0]   e_fail [c_N];
  logic [3:0]   e_zt   [c_N];

  always @(posedge clk) begin
    int s, v;
    logic z;
    logic [3:0] ex;
    if (rst) m_valid = 1'b1;
    for (int d = 0; d < c_N; d++) begin
      s  = settle_of(d);
      ex = exp_of(d);
      z  = gmode ? 1'b0 : (e_a[d] & e_b[d]);
      if (rst) begin
        m_run[d] = 0; m_dc[d] = 0; m_t[d] = 0;
        e_a[d] = 0; e_b[d] = 0; e_pass[d] = 0; e_fail[d] = 0; e_zt[d] = 0;
      end else if (m_run[d]) begin
        v = m_t[d] / (s + 1);
        if (abort) begin
          m_run[d] = 0; e_pass[d] = 0; e_a[d] = 0; e_b[d] = 0;
        end else if ((m_t[d] % (s + 1)) == s) begin
          e_fail[d][v] = z ^ ex[v];
          e_zt[d][v]   = z;
          if (v == 3) begin
            m_run[d] = 0; m_dc[d] = 1; e_pass[d] = (e_fail[d] == 4'd0);
          end else begin
            {e_a[d], e_b[d]} = 2'(v + 1);
          end
        end
        m_t[d]++;
      end else if (m_dc[d]) begin
        m_dc[d] = 0; e_a[d] = 0; e_b[d] = 0;
      end else if (start) begin
        m_run[d] = 1; m_t[d] = 0; e_fail[d] = 0; e_pass[d] = 0; e_zt[d] = 0;
        e_a[d] = 0; e_b[d] = 0;
      end
      e_busy[d] = m_run[d];
      e_done[d] = m_dc[d];
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int d = 0; d < c_N; d++) begin
        chk("a_out",    d, a_o[d],    e_a[d]);
        chk("b_out",    d, b_o[d],    e_b[d]);
        chk("busy",     d, busy_o[d], e_busy[d]);
        chk("done",     d, done_o[d], e_done[d]);
        chk("pass",     d, pass_o[d], e_pass[d]);
        chk("fail_vec", d, fail_o[d], e_fail[d]);
`ifdef GATE_SWEEP_CAPTURE_EN
        chk("z_table",  d, zt_o[d],   e_zt[d]);
`endif
      end
    end
  end

  // ---------------- directed scenarios ----------------
  int             t_done [c_N];
  int             n_done [c_N];
  logic [c_N-1:0] s_busy, s_done, s_pass, s_a, s_b;
  logic [3:0]     s_fail [c_N];

  // The start pulse is in cycle 0. Cycle k is observed at the k-th
  // following negedge. Inputs set there are sampled by the next posedge.
  task automatic scenario(input int re1, input int re2, input int ab_at,
                          input int rst_at, input int snap_at);
    for (int d = 0; d < c_N; d++) begin t_done[d] = 0; n_done[d] = 0; end
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = (k == re1) || (k == re2);
      abort = (k == ab_at);
      rst   = (k == rst_at);
      for (int d = 0; d < c_N; d++) begin
        if (done_o[d] === 1'b1) begin
          n_done[d]++;
          if (t_done[d] == 0) t_done[d] = k;
        end
      end
      if (k == snap_at) begin
        s_busy = busy_o; s_done = done_o; s_pass = pass_o; s_a = a_o; s_b = b_o;
        for (int d = 0; d < c_N; d++) s_fail[d] = fail_o[d];
      end
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; gmode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 0, busy_o, 0);
    chk("rst_done", 0, done_o, 0);
    chk("rst_pass", 0, pass_o, 0);
    chk("rst_ab",   0, {a_o, b_o}, 0);
    chk("rst_fail", 0, fail_o[0], 0);
    rst = 1'b0;
    @(negedge clk);

    // Good AND gate against AND / NAND / OR tables
    scenario(0, 0, 0, 0, 0);
    chk("lat_and",  0, t_done[0], 13);
    chk("lat_nand", 1, t_done[1], 13);
    chk("lat_s1",   2, t_done[2], 9);
    chk("ndone",    0, n_done[0], 1);
    chk("pass1",    0, pass_o, 3'b001);
    chk("fail_and", 0, fail_o[0], 4'b0000);
    chk("fail_nand",1, fail_o[1], 4'b1111);
    chk("fail_or",  2, fail_o[2], 4'b0110);
`ifdef GATE_SWEEP_CAPTURE_EN
    chk("ztab_and", 0, zt_o[0], 4'b1000);
`endif

    // Gate output stuck at 0
    gmode = 1'b1;
    scenario(0, 0, 0, 0, 0);
    chk("pass0",     0, pass_o, 3'b000);
    chk("fail0_and", 0, fail_o[0], 4'b1000);
    chk("fail0_nand",1, fail_o[1], 4'b0111);
    chk("fail0_or",  2, fail_o[2], 4'b1110);
`ifdef GATE_SWEEP_CAPTURE_EN
    chk("ztab0",     0, zt_o[0], 4'b0000);
`endif
    gmode = 1'b0;

    // Abort in cycle 4: dut0/1 are in the second SETTLE, dut2 is in SAMPLE idx1
    scenario(0, 0, 4, 0, 5);
    chk("ab_busy", 0, s_busy, 0);
    chk("ab_done", 0, s_done, 0);
    chk("ab_pass", 0, s_pass, 0);
    chk("ab_ab",   0, {s_a, s_b}, 0);
    chk("ab_ndone",0, n_done[0] + n_done[1] + n_done[2], 0);
    chk("ab_fail", 1, fail_o[1], 4'b0001);
    chk("ab_fail", 2, fail_o[2], 4'b0000);

    // Start re-pulsed in cycles 3 and 12
    scenario(3, 12, 0, 0, 0);
    chk("rp_lat",   0, t_done[0], 13);
    chk("rp_ndone", 0, n_done[0], 1);
    chk("rp_ndone", 2, n_done[2], 2);
    chk("rp_pass",  0, pass_o[0], 1);
    scenario(0, 0, 0, 0, 0);
    chk("rerun_lat", 0, t_done[0], 13);
    chk("rerun_pass",0, pass_o[0], 1);

    // Reset in cycle 7 (dut0 idx=2 SETTLE), then a normal sweep
    scenario(0, 0, 0, 7, 8);
    chk("rs_busy", 0, s_busy, 0);
    chk("rs_done", 0, s_done, 0);
    chk("rs_pass", 0, s_pass, 0);
    chk("rs_ab",   0, {s_a, s_b}, 0);
    chk("rs_fail", 1, s_fail[1], 0);
    chk("rs_ndone",0, n_done[0] + n_done[1] + n_done[2], 0);
    scenario(0, 0, 0, 0, 0);
    chk("post_rs_lat",  0, t_done[0], 13);
    chk("post_rs_pass", 0, pass_o[0], 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
